// File: rtl/sm_to_twos_serial_pkg.sv
// rtl/sm_to_twos_serial_pkg.sv - shared FSM encoding and counter sizing for the serial sign-magnitude converter
package sm_to_twos_serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } smtc_state_t;

  // Bit counter must hold 0..n, so it is sized for n+1 values.
  function automatic int cnt_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/halfADDER.sv
// rtl/halfADDER.sv - one-bit half adder
module halfADDER (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule

// File: rtl/sm_to_twos_serial.sv
// rtl/sm_to_twos_serial.sv - bit-serial sign-magnitude to two's-complement converter; SMTC_NEGZERO_FLAG_EN adds neg_zero
module sm_to_twos_serial
  import sm_to_twos_serial_pkg::*;
#(
  parameter int N = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] out_data
`ifdef SMTC_NEGZERO_FLAG_EN
  ,
  output logic         neg_zero
`endif
);

  localparam int CW = cnt_width(N);

  smtc_state_t   state;
  logic [N-1:0]  mag_sh;
  logic          sign;
  logic          carry;
  logic [CW-1:0] cnt;
  logic          bit_x;
  logic          ha_sum;
  logic          ha_carry;

  // Conditional invert of the current magnitude bit, then ripple the +1 serially.
  assign bit_x = mag_sh[0] ^ sign;

  halfADDER u_ha (
    .a     (bit_x),
    .b     (carry),
    .sum   (ha_sum),
    .carry (ha_carry)
  );

  assign in_ready = (state == IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      mag_sh    <= '0;
      sign      <= 1'b0;
      carry     <= 1'b0;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Sign bit is replaced by 0 so the final step yields s XOR carry.
            mag_sh <= {1'b0, in_data[N-2:0]};
            sign   <= in_data[N-1];
            carry  <= in_data[N-1];
            cnt    <= '0;
            state  <= SHIFT;
          end
        end
        SHIFT: begin
          out_data <= {ha_sum, out_data[N-1:1]};
          mag_sh   <= mag_sh >> 1;
          carry    <= ha_carry;
          cnt      <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef SMTC_NEGZERO_FLAG_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      neg_zero <= 1'b0;
    end else if (state == IDLE && in_valid) begin
      neg_zero <= in_data[N-1] && (in_data[N-2:0] == '0);
    end
  end
`endif

endmodule

// File: tb/tb_sm_to_twos_serial.sv
// tb/tb_sm_to_twos_serial.sv - scoreboard bench for sm_to_twos_serial (N=8)
module tb_sm_to_twos_serial;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] out_data;
`ifdef SMTC_NEGZERO_FLAG_EN
  logic         neg_zero;
`endif

  typedef struct packed {
    logic [N-1:0] data;
    logic         nz;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  sm_to_twos_serial #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef SMTC_NEGZERO_FLAG_EN
    ,
    .neg_zero  (neg_zero)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [N-1:0] ref_model(input logic [N-1:0] x);
    logic [N:0] t;
    if (!x[N-1]) return x;
    t = (N+1)'(1 << N) - {2'b00, x[N-2:0]};
    return t[N-1:0];
  endfunction

  // Monitor: every completed output handshake is matched against the queue head.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_output: got 0x%0h expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          check("out_data", {24'd0, out_data}, {24'd0, e.data});
`ifdef SMTC_NEGZERO_FLAG_EN
          check("neg_zero", {31'd0, neg_zero}, {31'd0, e.nz});
`endif
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic run_word(input logic [N-1:0] d, input logic [N-1:0] e, input bit rnd, input bit chk_lat);
    int lat;
    bit seen;
    bit done;
    seen = 1'b0;
    done = 1'b0;
    @(negedge clk);
    for (int w = 0; w < 40 && !in_ready; w++) @(negedge clk);
    if (!in_ready) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_in_ready: got 0 expected 1");
      return;
    end
    in_data  = d;
    in_valid = 1'b1;
    exp_q.push_back('{data: e, nz: (d == 8'h80)});
    @(posedge clk);
    #1 in_valid = 1'b0;
    lat = 0;
    for (int c = 0; c < 80 && !done; c++) begin
      @(negedge clk);
      if (out_valid && !seen) begin
        seen = 1'b1;
        if (chk_lat) check("latency", lat, N);
      end
      if (out_valid && out_ready) done = 1'b1;
      @(posedge clk);
      lat++;
      #1 out_ready = done ? 1'b0 : (rnd ? 1'($urandom_range(0, 1)) : 1'b1);
    end
    if (!done) begin
      n_cmp++;
      n_bad++;
      $display("FAIL timeout_out_valid: got none expected result for 0x%0h", d);
    end
  endtask

  initial begin : stim
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_data", {24'd0, out_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("idle_in_ready", {31'd0, in_ready}, 32'd1);

    run_word(8'h05, 8'h05, 1'b0, 1'b1);
    run_word(8'h85, 8'hFB, 1'b0, 1'b0);
    run_word(8'hFF, 8'h81, 1'b0, 1'b0);
    run_word(8'h80, 8'h00, 1'b0, 1'b0);
    run_word(8'h7F, 8'h7F, 1'b0, 1'b0);
    run_word(8'h81, 8'hFF, 1'b0, 1'b0);

    // Back-pressure: hold out_ready low in DONE and try to sneak in another word.
    @(negedge clk);
    in_data  = 8'h85;
    in_valid = 1'b1;
    exp_q.push_back('{data: 8'hFB, nz: 1'b0});
    @(posedge clk);
    #1 in_valid = 1'b0;
    for (int k = 0; k < 20 && !out_valid; k++) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check("stall_out_data", {24'd0, out_data}, 32'h000000FB);
      check("stall_in_ready", {31'd0, in_ready}, 32'd0);
      in_valid = (i == 1);
      in_data  = 8'h11;
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    check("post_hs_out_valid", {31'd0, out_valid}, 32'd0);
    check("post_hs_in_ready", {31'd0, in_ready}, 32'd1);
    repeat (12) @(negedge clk);
    check("ignored_word_idle", {31'd0, in_ready}, 32'd1);

    // Reset during the 4th SHIFT cycle drops the word in flight.
    @(negedge clk);
    in_data  = 8'h85;
    in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check("midrst_out_data", {24'd0, out_data}, 32'd0);
`ifdef SMTC_NEGZERO_FLAG_EN
    check("midrst_neg_zero", {31'd0, neg_zero}, 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    #1 check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    run_word(8'h03, 8'h03, 1'b0, 1'b0);

    for (int v = 0; v < 256; v++) begin
      run_word(8'(v), ref_model(8'(v)), 1'b1, 1'b0);
    end

    out_ready = 1'b1;
    repeat (15) @(negedge clk);
    check("queue_empty", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
